// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler: round-robin shared square-accumulate (acc += d*d) engine.
// NUM_REQ requesters take turns sending whole bursts; each burst's sum is
// presented with the requester id on a valid/ready result port.
// Optional feature: define MAC_SAT_EN for saturating accumulation with a
// sticky out_sat flag; otherwise the accumulator wraps and out_sat is 0.
module mac_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_trunc,
  output logic                       out_sat,
  output logic                       busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [ID_W-1:0]    sel;
  logic [7:0]         sample;
  logic [15:0]        prod;
  logic               fire;
  logic               done;
  int                 idx;

`ifdef MAC_SAT_EN
  logic               sat_q, sat_d;
  logic [ACC_W:0]     sum;
`endif

  // Next-state, arbitration and accumulator sequencing
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
`ifdef MAC_SAT_EN
    sat_d     = sat_q;
    sum       = '0;
`endif
    found     = 1'b0;
    sel       = '0;
    idx       = 0;

    // first valid requester at or after the rr pointer, wrapping
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(NUM_REQ);
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end

    sample = req_data[8*gnt_q +: 8];
    prod   = sample * sample;
    fire   = req_valid[gnt_q] & req_ready_q[gnt_q];
    done   = req_last[gnt_q] || (cnt_q == CNT_W'(MAX_LEN - 1));

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = sel;
          ptr_d   = ID_W'((int'(sel) + 1) % int'(NUM_REQ));
          acc_d   = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
`ifdef MAC_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        if (fire) begin
`ifdef MAC_SAT_EN
          sum = {1'b0, acc_q} + (ACC_W+1)'(prod);
          if (sum[ACC_W]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
`else
          acc_d = acc_q + ACC_W'(prod);
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (done) begin
            trunc_d = ~req_last[gnt_q];
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == RUN) ? (NUM_REQ'(1) << gnt_d) : '0;
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      req_ready_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MAC_SAT_EN
  // Sticky saturation flag, cleared on each grant
  always_ff @(posedge clk) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end
  assign out_sat = sat_q;
`else
  assign out_sat = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_id    = gnt_q;
  assign out_trunc = trunc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed bench for mac_rr_scheduler with per-requester sample queues and
// a result scoreboard; honours MAC_SAT_EN for expected saturation values.
module tb_mac_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned MAX_LEN = 16;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } sample_t;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [1:0]       id;
    logic             trunc;
    logic             sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_data;
  logic [1:0]           out_id;
  logic                 out_trunc;
  logic                 out_sat;
  logic                 busy;

  sample_t              src_q [NUM_REQ][$];
  exp_t                 sb_q[$];
  logic [NUM_REQ-1:0]   fire;
  int                   checks = 0;
  int                   errors = 0;

  always #5 clk = ~clk;

  mac_rr_scheduler #(.NUM_REQ(NUM_REQ), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .out_trunc(out_trunc), .out_sat(out_sat), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Queue a burst for requester id and push the results the burst must produce
  task automatic burst(input int id, input int vals[$], input bit last_end, input bit want);
    int      acc;
    int      cnt;
    bit      sat;
    sample_t s;
    exp_t    e;
    acc = 0; cnt = 0; sat = 1'b0;
    for (int k = 0; k < vals.size(); k++) begin
      s.d    = 8'(vals[k]);
      s.last = last_end && (k == vals.size() - 1);
      src_q[id].push_back(s);
      if (cnt == 0) begin acc = 0; sat = 1'b0; end
      acc = acc + vals[k] * vals[k];
`ifdef MAC_SAT_EN
      if (acc >= 2**ACC_W) begin acc = 2**ACC_W - 1; sat = 1'b1; end
`else
      acc = acc % (2**ACC_W);
`endif
      cnt++;
      if (s.last || cnt == int'(MAX_LEN)) begin
        if (want) begin
          e.data  = ACC_W'(acc);
          e.id    = 2'(id);
          e.trunc = !s.last;
          e.sat   = sat;
          sb_q.push_back(e);
        end
        cnt = 0;
      end
    end
  endtask

  // Wait for all sources drained and the DUT idle with no pending result
  task automatic wait_quiet(input string tag);
    int  n;
    bit  empty;
    n = 0;
    forever begin
      empty = 1'b1;
      for (int i = 0; i < int'(NUM_REQ); i++) if (src_q[i].size() != 0) empty = 1'b0;
      if ((empty && !busy && !out_valid && sb_q.size() == 0) || n >= 400) break;
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  // Record which handshakes will complete on the coming rising edge
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < int'(NUM_REQ); i++) fire[i] = req_valid[i] & req_ready[i] & ~reset;
  end

  // Source driver: retire accepted samples and present the next one
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (fire[i] && src_q[i].size() > 0) src_q[i].delete(0);
      fire[i] = 1'b0;
      if (src_q[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = src_q[i][0].d;
        req_last[i]       = src_q[i][0].last;
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'd0;
        req_last[i]       = 1'b0;
      end
    end
  end

  // Result monitor: compare each accepted result with the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset && out_valid && out_ready) begin
      chk("result_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("out_data",  32'(out_data),  32'(e.data));
        chk("out_id",    32'(out_id),    32'(e.id));
        chk("out_trunc", 32'(out_trunc), 32'(e.trunc));
        chk("out_sat",   32'(out_sat),   32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int v[$];
    int n;
    int seen;

    reset     = 1'b1;
    out_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    chk("rst_out_trunc", 32'(out_trunc), 32'd0);
    reset = 1'b0;

    // basic burst 3,4,5 on requester 0 and its latencies
    out_ready = 1'b1;
    burst(0, '{3, 4, 5}, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_no_early_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'b0001);
    n = 0;
    while (!(req_valid[0] && req_ready[0] && req_last[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1_last_seen", 32'(n < 50), 32'd1);
    @(negedge clk);
    chk("t1_out_latency", 32'(out_valid), 32'd1);
    wait_quiet("t1_done");

    // round robin from reset: 1 then 3, then pointer at 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    burst(1, '{7}, 1'b1, 1'b1);
    burst(3, '{2, 2}, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2_first_grant", 32'(req_ready), 32'b0010);
    wait_quiet("t2a_done");
    burst(0, '{1}, 1'b1, 1'b1);
    burst(1, '{10}, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2_wrap_grant", 32'(req_ready), 32'b0001);
    wait_quiet("t2b_done");

    // truncation at MAX_LEN, remainder in a later burst
    v = {};
    repeat (20) v.push_back(1);
    burst(2, v, 1'b1, 1'b1);
    wait_quiet("t3_done");

    // back-pressure in HOLD
    out_ready = 1'b0;
    burst(0, '{6, 8}, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_hold_reached", 32'(n < 50), 32'd1);
    burst(1, '{3}, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid",     32'(out_valid), 32'd1);
      chk("t4_hold_data",      32'(out_data),  32'd100);
      chk("t4_hold_id",        32'(out_id),    32'd0);
      chk("t4_hold_req_ready", 32'(req_ready), 32'd0);
      chk("t4_hold_busy",      32'(busy),      32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_idle_busy",  32'(busy),      32'd0);
    chk("t4_idle_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t4_next_grant", 32'(req_ready), 32'b0010);
    wait_quiet("t4_done");

    // overflow: wrap or saturate, then flag clears on the next grant
    burst(1, '{255, 255}, 1'b1, 1'b1);
    burst(1, '{2}, 1'b1, 1'b1);
    wait_quiet("t5_done");

    // reset in RUN after two accepted samples
    burst(0, '{1, 2, 3, 4}, 1'b1, 1'b0);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 50) begin
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) seen++;
      n++;
    end
    chk("t6_two_accepts", 32'(seen), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    src_q[0].delete();
    @(negedge clk);
    chk("t6_rst_busy",      32'(busy),      32'd0);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    burst(0, '{2}, 1'b1, 1'b1);
    burst(3, '{5}, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_ptr_zero_grant", 32'(req_ready), 32'b0001);
    wait_quiet("t6_done");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
